codificador7a3: RTL and testbench
=================================

Name: codificador7a3

Overview:
- Registered 7-to-3 priority encoder.
- Converts a 7-bit request vector X into the 3-bit index of its highest set bit.
- Also produces a valid flag and a multiple-hot error flag.
- Used wherever a one-hot selector must be compressed to a binary code, e.g. a channel select ahead of a mux or a segment decoder.

Parameters:
- none; widths are fixed at 7 in and 3 out.

Ports:
- clk  input  1  rising-edge clock; all outputs register on it.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when 0, the outputs hold their value.
- X  input  7  request vector; bit i represents code i.
- Salida  output  3  registered binary index of the highest set bit of X.
- Valido  output  1  registered; 1 when at least one bit of X was set.
- Multiple  output  1  registered; 1 when two or more bits of X were set.

Behaviour:
- Reset:
  - rst=1 forces Salida=3'b000, Valido=0, Multiple=0 immediately, without waiting for clk.
  - Outputs stay at these values while rst is high.
  - First capture is at the first rising clk edge after rst deasserts.
- Encoding (combinational, registered on clk when en=1):
  - Priority is highest bit first: X[6]=1 -> 6; else X[5] -> 5; else X[4] -> 4; X[3] -> 3; X[2] -> 2; X[1] -> 1; X[0] -> 0.
  - X=0 -> code 0 with Valido=0.
  - Salida=0 is ambiguous on its own; Valido distinguishes X[0]-only (Valido=1) from X=0 (Valido=0).
  - Multiple = (popcount(X) >= 2). Salida still reports the highest set bit in that case.
- Latency: exactly 1 clk. Outputs reflect the X sampled at the previous rising edge with en=1.
- en=0: Salida, Valido and Multiple hold their last values; X is ignored.
- Outputs never change except on a rising clk edge or an rst assertion. There are no combinational paths from X to any output.
- Reset mid-operation:
  - Asynchronous clear takes effect immediately.
  - Any capture pending at that edge is discarded.
- Simultaneous rst and clk edge: reset wins.
- X containing X/Z values is undefined; the bench must drive known values only.

Test Plan:
- Reset: assert rst with X=7'b1000000 and en=1 -> Salida=000, Valido=0, Multiple=0 at once; values held for 3 clocks while rst stays high.
- One-hot walk: en=1, apply 0000000, 0000010, 0000100, 0001000, 0010000, 0100000, 1000000, 0000000, one per clock.
  - Salida one cycle later: 000, 001, 010, 011, 100, 101, 110, 000.
  - Valido one cycle later: 0, 1, 1, 1, 1, 1, 1, 0.
  - Multiple: 0 throughout.
- Bit0 vs zero: X=0000001 -> Salida=000, Valido=1; then X=0000000 -> Salida=000, Valido=0.
- Priority and multiple-hot:
  - X=0101010 -> Salida=101, Valido=1, Multiple=1.
  - X=1111111 -> Salida=110, Multiple=1.
  - X=0000011 -> Salida=001, Multiple=1.
- Enable hold: capture X=0001000 (Salida=011), then drop en and change X to 1000000 for 4 clocks -> Salida stays 011; raise en -> Salida=110 on the next edge.
- Async reset mid-run: with Salida=110, pulse rst between clock edges -> outputs clear before the next edge; after release, X=0000100 -> Salida=010 one clock later.

Source files
------------

// File: rtl/codificador7a3.sv
// Registered 7-to-3 priority encoder with valid and multiple-hot flags.
// Highest set bit of X wins; all outputs update one clock after capture.
module codificador7a3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] X,
    output logic [2:0] Salida,
    output logic       Valido,
    output logic       Multiple
);

    logic [6:0] hi;
    logic [2:0] code;
    logic       any;
    logic       multi;

    // Mask off everything below the top set bit so the cases are one-hot.
    always_comb begin
        hi    = 7'd0;
        hi[6] = X[6];
        hi[5] = X[5] & ~X[6];
        hi[4] = X[4] & ~(|X[6:5]);
        hi[3] = X[3] & ~(|X[6:4]);
        hi[2] = X[2] & ~(|X[6:3]);
        hi[1] = X[1] & ~(|X[6:2]);
        hi[0] = X[0] & ~(|X[6:1]);
    end

    always_comb begin
        code = 3'd0;
        unique case (1'b1)
            hi[6]:   code = 3'd6;
            hi[5]:   code = 3'd5;
            hi[4]:   code = 3'd4;
            hi[3]:   code = 3'd3;
            hi[2]:   code = 3'd2;
            hi[1]:   code = 3'd1;
            hi[0]:   code = 3'd0;
            default: code = 3'd0;
        endcase
    end

    assign any   = |X;
    assign multi = |(X & (X - 7'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Salida   <= 3'd0;
            Valido   <= 1'b0;
            Multiple <= 1'b0;
        end else if (en) begin
            Salida   <= code;
            Valido   <= any;
            Multiple <= multi;
        end
    end

endmodule

// File: tb/tb_codificador7a3.sv
// Directed bench for codificador7a3.
// Inputs change on the falling edge; outputs sampled 1ns after the rising edge.
module tb_codificador7a3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] X;
    logic [2:0] Salida;
    logic       Valido;
    logic       Multiple;

    int checks;
    int failures;

    codificador7a3 dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .X        (X),
        .Salida   (Salida),
        .Valido   (Valido),
        .Multiple (Multiple)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] s,
                           input logic v, input logic m);
        chk({tag, ".Salida"}, Salida, s);
        chk({tag, ".Valido"}, {2'b00, Valido}, {2'b00, v});
        chk({tag, ".Multiple"}, {2'b00, Multiple}, {2'b00, m});
    endtask

    task automatic step(input string tag, input logic [6:0] x,
                        input logic [2:0] s, input logic v, input logic m);
        @(negedge clk);
        X = x;
        @(posedge clk);
        #1;
        chk_all(tag, s, v, m);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        en       = 1'b1;
        X        = 7'b1000000;

        // Load a nonzero value, then reset asynchronously mid-cycle.
        @(posedge clk);
        #1;
        chk("preload", Salida, 3'b110);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("reset_async", 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all("reset_hold", 3'b000, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // One-hot walk.
        step("walk0", 7'b0000000, 3'b000, 1'b0, 1'b0);
        step("walk1", 7'b0000010, 3'b001, 1'b1, 1'b0);
        step("walk2", 7'b0000100, 3'b010, 1'b1, 1'b0);
        step("walk3", 7'b0001000, 3'b011, 1'b1, 1'b0);
        step("walk4", 7'b0010000, 3'b100, 1'b1, 1'b0);
        step("walk5", 7'b0100000, 3'b101, 1'b1, 1'b0);
        step("walk6", 7'b1000000, 3'b110, 1'b1, 1'b0);
        step("walk7", 7'b0000000, 3'b000, 1'b0, 1'b0);

        // Bit 0 versus all-zero.
        step("bit0", 7'b0000001, 3'b000, 1'b1, 1'b0);
        step("zero", 7'b0000000, 3'b000, 1'b0, 1'b0);

        // Priority with multiple bits set.
        step("multi_2a", 7'b0101010, 3'b101, 1'b1, 1'b1);
        step("multi_all", 7'b1111111, 3'b110, 1'b1, 1'b1);
        step("multi_low", 7'b0000011, 3'b001, 1'b1, 1'b1);
        step("multi_hi2", 7'b1100000, 3'b110, 1'b1, 1'b1);

        // Enable hold.
        step("en_cap", 7'b0001000, 3'b011, 1'b1, 1'b0);
        @(negedge clk);
        en = 1'b0;
        X  = 7'b1000001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk_all("en_hold", 3'b011, 1'b1, 1'b0);
        end
        @(negedge clk);
        en = 1'b1;
        step("en_resume", 7'b1000000, 3'b110, 1'b1, 1'b0);

        // Async reset between edges, then recover.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("reset_mid", 3'b000, 1'b0, 1'b0);
        X = 7'b0000100;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("after_reset", 3'b010, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
